mux_nx1_pipe: RTL and testbench
===============================

// Module: mux_nx1_pipe
// PURPOSE
//  Parametrised N:1, WIDTH-bit data selector with one registered pipeline stage and a
//  valid/ready handshake on both sides. It is the successor to the fixed 2:1 32-bit mux
//  used in the datapath. It serves pipelined MIPS stages: writeback select, forwarding
//  select and ALU operand select.
//  A 2-entry skid buffer lets a downstream stall propagate without dropping or duplicating data.
// PARAMETERS
//  WIDTH    32  data width of each input and of the output
//  NUM_IN   4   number of data inputs (2..16)
//  SEL_W    localparam = $clog2(NUM_IN); width of the select field
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              asynchronous, active-high reset
//  in_data    in   NUM_IN*WIDTH   flattened inputs; input k = in_data[k*WIDTH +: WIDTH]
//  in_sel     in   SEL_W          index of the input to forward
//  in_valid   in   1              upstream beat valid
//  in_ready   out  1              block can accept a beat
//  out_data   out  WIDTH          selected, registered data
//  out_sel    out  SEL_W          in_sel that produced out_data
//  out_valid  out  1              output beat valid
//  out_ready  in   1              downstream accepts the beat
//  sel_err    out  1              sticky flag: an in_sel >= NUM_IN was accepted
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-high.
//  - Reset values: out_data=0, out_sel=0, out_valid=0, sel_err=0, in_ready=1 (state EMPTY).
//    Both buffer entries are cleared.
//  - Accept and deliver events:
//    - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
//    - Latency is 1 cycle: a beat accepted at edge n is on out_data after edge n.
//  - Selection rule:
//    - Selected value = input[in_sel], captured at accept together with in_sel.
//    - If in_sel >= NUM_IN (possible when NUM_IN is not a power of 2), the data is 0.
//      The beat is still passed and sel_err is set. sel_err stays set until reset.
//  - State machine (state register, 2 bits):
//    EMPTY: main entry empty.
//      accept -> ONE (main <= beat).
//    ONE: main entry holds a beat.
//      accept & deliver  -> ONE (main <= new beat)
//      accept & !deliver -> FULL (skid <= new beat)
//      !accept & deliver -> EMPTY
//      neither           -> ONE (hold)
//    FULL: main and skid entries both hold beats; in_ready=0.
//      deliver  -> ONE (main <= skid)
//      !deliver -> FULL (hold)
//  - Handshake outputs:
//    - in_ready is driven from the state register only (1 in EMPTY/ONE, 0 in FULL).
//      There is no combinational path from out_ready to in_ready.
//    - out_valid = (state != EMPTY). out_data and out_sel are driven from the main entry.
//  - Ordering and stability:
//    - Beats leave in acceptance order. None are lost or duplicated.
//    - out_data, out_sel and out_valid are stable while out_valid & !out_ready.
//  - in_valid while FULL is ignored; the upstream must hold its beat.
//  - Reset mid-operation discards all buffered beats at once, with no partial delivery.
// STRUCTURE
//  - Shared header mux_pkg.vh holds:
//    - state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2
//    - the clog2 helper function
//    - MUX_MAX_IN=16
//  - Sub-module mux_nx1_comb (WIDTH, NUM_IN): purely combinational N:1 select.
//    Its outputs are data and an out_of_range flag. It is instantiated once at the
//    input side.
//  - Top level: state register, main/skid data and sel registers, sel_err flop.
// TESTING
//  1. Reset: assert reset asynchronously mid-cycle.
//     -> outputs go to 0 at once, in_ready=1, sel_err=0.
//  2. Streaming (NUM_IN=4): out_ready=1; drive sel 0,1,2,3 with input k=32'h1000_000k.
//     -> out_data 0x10000000..0x10000003 one cycle later, back-to-back, out_sel matches.
//  3. Stall:
//     - Accept A (sel 2). Hold out_ready=0 and present B.
//       -> B accepted, FULL, in_ready=0.
//     - Present C.
//       -> C not accepted.
//     - Release out_ready.
//       -> A, then B, then C out, in order; A held stable during the stall.
//  4. Out of range (NUM_IN=3): sel=3.
//     -> out_data=0, sel_err=1 and still 1 after 20 more valid beats.
//  5. Simultaneous accept and deliver in ONE for 100 random beats.
//     -> state stays ONE and the scoreboard matches.
//  6. Reset while FULL.
//     -> out_valid=0 and both entries dropped; first beat after reset comes out next cycle.

Source files
------------

// File: rtl/mux_nx1_pipe_pkg.sv
// Shared definitions for the N:1 pipelined selector: FSM encodings, limits and
// a constant-evaluable ceil(log2) helper used to size the select field.
package mux_nx1_pipe_pkg;

    localparam int MUX_MAX_IN = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Bounded loop so the helper elaborates as a constant in every tool.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_nx1_comb.sv
// Purely combinational N:1 select; an index with no matching input yields zero
// data and raises out_of_range.
module mux_nx1_comb
    import mux_nx1_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_f(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    out_of_range
);

    // AND-OR select: each input contributes only when its index matches.
    always_comb begin
        data = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            data = data | ({WIDTH{32'(sel) == k}} & in_data[k*WIDTH +: WIDTH]);
        end
        out_of_range = (32'(sel) >= NUM_IN);
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// Registered N:1 selector with valid/ready on both sides and a 2-entry skid
// buffer (main + skid) so a downstream stall never drops or repeats a beat.
module mux_nx1_pipe
    import mux_nx1_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_f(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    state_e             state_r;
    logic [WIDTH-1:0]   main_data_r;
    logic [SEL_W-1:0]   main_sel_r;
    logic [WIDTH-1:0]   skid_data_r;
    logic [SEL_W-1:0]   skid_sel_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               sel_err_r;

    logic [WIDTH-1:0]   sel_data_s;
    logic               oor_s;
    logic               accept_s;
    logic               deliver_s;

    mux_nx1_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .in_data      (in_data),
        .sel          (in_sel),
        .data         (sel_data_s),
        .out_of_range (oor_s)
    );

    assign accept_s  = in_valid & in_ready_r;
    assign deliver_s = out_valid_r & out_ready;

    // Handshake flags are registered alongside the state, so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            main_data_r <= {WIDTH{1'b0}};
            main_sel_r  <= {SEL_W{1'b0}};
            skid_data_r <= {WIDTH{1'b0}};
            skid_sel_r  <= {SEL_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sel_err_r   <= 1'b0;
        end else begin
            sel_err_r <= sel_err_r | (accept_s & oor_s);
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_data_r <= sel_data_s;
                        main_sel_r  <= in_sel;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && deliver_s) begin
                        main_data_r <= sel_data_s;
                        main_sel_r  <= in_sel;
                        state_r     <= ST_ONE;
                    end else if (accept_s) begin
                        skid_data_r <= sel_data_s;
                        skid_sel_r  <= in_sel;
                        state_r     <= ST_FULL;
                        in_ready_r  <= 1'b0;
                    end else if (deliver_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (deliver_s) begin
                        main_data_r <= skid_data_r;
                        main_sel_r  <= skid_sel_r;
                        state_r     <= ST_ONE;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_FULL;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_data_r;
    assign out_sel   = main_sel_r;
    assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: a 4-input instance for streaming, stall,
// back-to-back and reset cases, and a 3-input instance for out-of-range select.
module tb_mux_nx1_pipe;

    logic         clk;
    logic         reset;

    logic [127:0] d4_in_data;
    logic [1:0]   d4_in_sel;
    logic         d4_in_valid;
    logic         d4_in_ready;
    logic [31:0]  d4_out_data;
    logic [1:0]   d4_out_sel;
    logic         d4_out_valid;
    logic         d4_out_ready;
    logic         d4_sel_err;

    logic [95:0]  d3_in_data;
    logic [1:0]   d3_in_sel;
    logic         d3_in_valid;
    logic         d3_in_ready;
    logic [31:0]  d3_out_data;
    logic [1:0]   d3_out_sel;
    logic         d3_out_valid;
    logic         d3_out_ready;
    logic         d3_sel_err;

    int checks;
    int errors;

    mux_nx1_pipe #(.WIDTH(32), .NUM_IN(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_data(d4_in_data), .in_sel(d4_in_sel), .in_valid(d4_in_valid),
        .in_ready(d4_in_ready), .out_data(d4_out_data), .out_sel(d4_out_sel),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .sel_err(d4_sel_err)
    );

    mux_nx1_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_data(d3_in_data), .in_sel(d3_in_sel), .in_valid(d3_in_valid),
        .in_ready(d3_in_ready), .out_data(d3_out_data), .out_sel(d3_out_sel),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .sel_err(d3_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_d4_const();
        for (int k = 0; k < 4; k++) d4_in_data[k*32 +: 32] = 32'h1000_0000 + k;
    endtask

    initial begin
        logic [31:0] exp_d;
        int          s;

        checks = 0;
        errors = 0;
        reset = 1'b1;
        load_d4_const();
        for (int k = 0; k < 3; k++) d3_in_data[k*32 +: 32] = 32'h2000_0000 + k;
        d4_in_sel = 2'd0; d4_in_valid = 1'b0; d4_out_ready = 1'b0;
        d3_in_sel = 2'd0; d3_in_valid = 1'b0; d3_out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", {63'd0, d4_out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, d4_in_ready}, 64'd1);
        chk("rst_out_data", {32'd0, d4_out_data}, 64'd0);
        #2 reset = 1'b0;

        // Asynchronous reset mid-cycle with a beat held in the main entry.
        d4_in_valid = 1'b1; d4_in_sel = 2'd1;
        step();
        d4_in_valid = 1'b0;
        chk("pre_rst_data", {32'd0, d4_out_data}, 64'h1000_0001);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, d4_out_valid}, 64'd0);
        chk("async_rst_data", {32'd0, d4_out_data}, 64'd0);
        chk("async_rst_sel", {62'd0, d4_out_sel}, 64'd0);
        chk("async_rst_ready", {63'd0, d4_in_ready}, 64'd1);
        chk("async_rst_err", {63'd0, d4_sel_err}, 64'd0);
        #1 reset = 1'b0;

        // Streaming, back-to-back.
        d4_out_ready = 1'b1; d4_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d4_in_sel = 2'(i);
            step();
            chk("stream_valid", {63'd0, d4_out_valid}, 64'd1);
            chk("stream_data", {32'd0, d4_out_data}, 64'h1000_0000 + 64'(i));
            chk("stream_sel", {62'd0, d4_out_sel}, 64'(i));
        end
        d4_in_valid = 1'b0;
        step();
        chk("stream_drain", {63'd0, d4_out_valid}, 64'd0);

        // Stall: A, B fill both entries; C must wait.
        d4_out_ready = 1'b0; d4_in_valid = 1'b1; d4_in_sel = 2'd2;
        step();
        chk("stall_a_data", {32'd0, d4_out_data}, 64'h1000_0002);
        d4_in_sel = 2'd1;
        step();
        chk("stall_full_ready", {63'd0, d4_in_ready}, 64'd0);
        chk("stall_a_hold", {32'd0, d4_out_data}, 64'h1000_0002);
        d4_in_sel = 2'd3;
        step();
        chk("stall_c_block", {63'd0, d4_in_ready}, 64'd0);
        chk("stall_a_hold2", {32'd0, d4_out_data}, 64'h1000_0002);
        chk("stall_a_sel", {62'd0, d4_out_sel}, 64'd2);
        chk("stall_a_valid", {63'd0, d4_out_valid}, 64'd1);
        d4_out_ready = 1'b1;
        step();
        chk("rel_b_data", {32'd0, d4_out_data}, 64'h1000_0001);
        chk("rel_ready", {63'd0, d4_in_ready}, 64'd1);
        step();
        chk("rel_c_data", {32'd0, d4_out_data}, 64'h1000_0003);
        chk("rel_c_sel", {62'd0, d4_out_sel}, 64'd3);
        d4_in_valid = 1'b0;
        step();
        chk("rel_empty", {63'd0, d4_out_valid}, 64'd0);

        // Out-of-range select on the 3-input instance.
        d3_out_ready = 1'b1; d3_in_valid = 1'b1; d3_in_sel = 2'd2;
        step();
        chk("n3_in2_data", {32'd0, d3_out_data}, 64'h2000_0002);
        chk("n3_err_clear", {63'd0, d3_sel_err}, 64'd0);
        d3_in_sel = 2'd3;
        step();
        chk("n3_oor_data", {32'd0, d3_out_data}, 64'd0);
        chk("n3_oor_sel", {62'd0, d3_out_sel}, 64'd3);
        chk("n3_oor_valid", {63'd0, d3_out_valid}, 64'd1);
        chk("n3_err_set", {63'd0, d3_sel_err}, 64'd1);
        for (int i = 0; i < 20; i++) begin
            d3_in_sel = 2'(i % 3);
            step();
        end
        chk("n3_last_data", {32'd0, d3_out_data}, 64'h2000_0001);
        chk("n3_err_sticky", {63'd0, d3_sel_err}, 64'd1);
        chk("n4_err_clear", {63'd0, d4_sel_err}, 64'd0);
        d3_in_valid = 1'b0;

        // 100 beats with simultaneous accept and deliver.
        d4_in_valid = 1'b1; d4_out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 4; k++) d4_in_data[k*32 +: 32] = $urandom;
            s = int'($urandom_range(0, 3));
            d4_in_sel = 2'(s);
            exp_d = d4_in_data[s*32 +: 32];
            step();
            chk("b2b_data", {32'd0, d4_out_data}, {32'd0, exp_d});
            chk("b2b_state_one", {62'd0, d4_out_valid, d4_in_ready}, 64'd3);
        end
        d4_in_valid = 1'b0;
        load_d4_const();
        step();
        chk("b2b_drain", {63'd0, d4_out_valid}, 64'd0);

        // Reset while FULL, then one beat afterwards.
        d4_out_ready = 1'b0; d4_in_valid = 1'b1; d4_in_sel = 2'd3;
        step();
        d4_in_sel = 2'd2;
        step();
        chk("pre_rst_full", {63'd0, d4_in_ready}, 64'd0);
        d4_in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("full_rst_valid", {63'd0, d4_out_valid}, 64'd0);
        chk("full_rst_ready", {63'd0, d4_in_ready}, 64'd1);
        #1 reset = 1'b0;
        d4_out_ready = 1'b1; d4_in_valid = 1'b1; d4_in_sel = 2'd0;
        step();
        chk("post_rst_data", {32'd0, d4_out_data}, 64'h1000_0000);
        chk("post_rst_valid", {63'd0, d4_out_valid}, 64'd1);
        d4_in_valid = 1'b0;
        step();
        chk("post_rst_no_stale", {63'd0, d4_out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
